// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared state encoding and PC constants for the fetch stage
package if_fetch_stage_pkg;
  typedef enum logic [1:0] {FETCH = 2'd0, READY = 2'd1, DRAIN = 2'd2} state_t;
  localparam int PC_STEP = 4;
  localparam int PC_RESET = 0;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: fetch address register (ports: clk, rst active-low sync, load/target word-aligned load, inc +4 step, pc out)
module fetch_pc_reg
  import if_fetch_stage_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  input  logic [N-1:0] target,
  output logic [N-1:0] pc
);
  always_ff @(posedge clk)
    if (!rst) pc <= N'(PC_RESET);
    else if (load) pc <= target & ~N'(3);
    else if (inc) pc <= pc + N'(PC_STEP);
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC + req/ack instruction fetch with redirect and freeze (ports: clk, rst active-low sync, freeze, branchTaken/branchAddr, memReq/memAddr/memAck/memData, valid/pc/instruction to IF/ID)
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         branchTaken,
  input  logic [N-1:0] branchAddr,
  output logic         memReq,
  output logic [N-1:0] memAddr,
  input  logic         memAck,
  input  logic [N-1:0] memData,
  output logic         valid,
  output logic [N-1:0] pc,
  output logic [N-1:0] instruction
);
  state_t state, state_d;
  logic [N-1:0] pc_q, redir, instr, pc_out, target;
  logic load, inc, redir_we, cap;
  // an in-flight redirect resolves to the latest target; a same-cycle branch beats the saved one
  assign target = (state == DRAIN && !branchTaken) ? redir : branchAddr;
  fetch_pc_reg #(.N(N)) u_pc (
    .clk(clk), .rst(rst), .load(load), .inc(inc), .target(target), .pc(pc_q)
  );
  always_comb begin
    state_d = state;
    load = 1'b0;
    inc = 1'b0;
    redir_we = 1'b0;
    cap = 1'b0;
    case (state)
      FETCH:
        if (branchTaken) begin
          load = memAck;
          redir_we = !memAck;
          state_d = memAck ? FETCH : DRAIN;
        end else if (memAck) begin
          cap = 1'b1;
          state_d = READY;
        end
      READY:
        if (branchTaken || !freeze) begin
          load = branchTaken;
          inc = !branchTaken;
          state_d = FETCH;
        end
      DRAIN:
        if (memAck) begin
          load = 1'b1;
          state_d = FETCH;
        end else redir_we = branchTaken;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= FETCH;
      redir <= '0;
      instr <= '0;
      pc_out <= '0;
    end else begin
      state <= state_d;
      if (redir_we) redir <= branchAddr & ~N'(3);
      if (cap) begin
        instr <= memData;
        pc_out <= pc_q + N'(PC_STEP);
      end
    end
  // outputs are forced quiet for the whole cycle reset is held, not just after the edge
  assign memReq = rst && state != READY;
  assign memAddr = rst ? pc_q : '0;
  assign valid = rst && state == READY;
  assign pc = rst ? pc_out : '0;
  assign instruction = rst ? instr : '0;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed vector bench for if_fetch_stage
module tb_if_fetch_stage;
  typedef struct {
    logic rst, frz, bt;
    logic [31:0] baddr;
    logic ack;
    logic [31:0] data;
    logic req;
    logic [31:0] addr;
    logic vld;
    logic [31:0] pcv, ins;
  } vec_t;
  logic clk = 0, rst = 0, freeze = 0, branchTaken = 0, memAck = 0;
  logic [31:0] branchAddr = 0, memData = 0;
  logic memReq, valid;
  logic [31:0] memAddr, pc, instruction;
  int n_vec = 0, n_err = 0;
  vec_t tbl[$];
  if_fetch_stage #(.N(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branchTaken(branchTaken), .branchAddr(branchAddr),
    .memReq(memReq), .memAddr(memAddr), .memAck(memAck), .memData(memData),
    .valid(valid), .pc(pc), .instruction(instruction)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic r, logic f, logic b, logic [31:0] ba, logic a, logic [31:0] d,
                              logic er, logic [31:0] ea, logic ev, logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.rst = r; v.frz = f; v.bt = b; v.baddr = ba; v.ack = a; v.data = d;
    v.req = er; v.addr = ea; v.vld = ev; v.pcv = ep; v.ins = ei;
    return v;
  endfunction
  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at step %0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask
  task automatic drive(logic r, logic f, logic b, logic [31:0] ba, logic a, logic [31:0] d);
    @(negedge clk);
    rst = r; freeze = f; branchTaken = b; branchAddr = ba; memAck = a; memData = d;
    #1;
  endtask
  initial begin
    bit seen;
    tbl.push_back(mk(0,0,0,0,0,0,                       0,32'h0,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,0,0,0,                       0,32'h0,0,32'h0,32'h0));
    tbl.push_back(mk(1,0,0,0,0,0,                       1,32'h0,0,32'h0,32'h0));
    tbl.push_back(mk(1,0,0,0,1,32'hE3A00001,            1,32'h0,0,32'h0,32'h0));
    tbl.push_back(mk(1,1,0,0,0,0,                       0,32'h0,1,32'h4,32'hE3A00001));
    tbl.push_back(mk(1,1,0,0,0,0,                       0,32'h0,1,32'h4,32'hE3A00001));
    tbl.push_back(mk(1,1,0,0,0,0,                       0,32'h0,1,32'h4,32'hE3A00001));
    tbl.push_back(mk(1,0,0,0,0,0,                       0,32'h0,1,32'h4,32'hE3A00001));
    tbl.push_back(mk(1,0,0,0,1,32'h11111111,            1,32'h4,0,32'h4,32'hE3A00001));
    tbl.push_back(mk(1,0,0,0,0,0,                       0,32'h4,1,32'h8,32'h11111111));
    tbl.push_back(mk(1,0,1,32'h103,0,0,                 1,32'h8,0,32'h8,32'h11111111));
    tbl.push_back(mk(1,0,0,0,0,0,                       1,32'h8,0,32'h8,32'h11111111));
    tbl.push_back(mk(1,0,0,0,1,32'hBAD00008,            1,32'h8,0,32'h8,32'h11111111));
    tbl.push_back(mk(1,0,1,32'h40,0,0,                  1,32'h100,0,32'h8,32'h11111111));
    tbl.push_back(mk(1,0,1,32'h80,0,0,                  1,32'h100,0,32'h8,32'h11111111));
    tbl.push_back(mk(1,0,0,0,1,32'hBAD00100,            1,32'h100,0,32'h8,32'h11111111));
    tbl.push_back(mk(1,0,0,0,1,32'h22222222,            1,32'h80,0,32'h8,32'h11111111));
    tbl.push_back(mk(1,1,1,32'h200,0,0,                 0,32'h80,1,32'h84,32'h22222222));
    tbl.push_back(mk(1,0,1,32'hFFFFFFFF,1,32'hBADBAD00, 1,32'h200,0,32'h84,32'h22222222));
    tbl.push_back(mk(1,0,0,0,1,32'h33333333,            1,32'hFFFFFFFC,0,32'h84,32'h22222222));
    tbl.push_back(mk(1,1,0,0,1,32'hDEADBEEF,            0,32'hFFFFFFFC,1,32'h0,32'h33333333));
    tbl.push_back(mk(1,0,0,0,0,0,                       0,32'hFFFFFFFC,1,32'h0,32'h33333333));
    tbl.push_back(mk(1,1,0,0,1,32'h44444444,            1,32'h0,0,32'h0,32'h33333333));
    tbl.push_back(mk(0,0,0,0,0,0,                       0,32'h0,0,32'h0,32'h0));
    tbl.push_back(mk(1,0,0,0,0,0,                       1,32'h0,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,0,1,32'h77777777,            0,32'h0,0,32'h0,32'h0));
    tbl.push_back(mk(1,0,0,0,1,32'h55555555,            1,32'h0,0,32'h0,32'h0));
    tbl.push_back(mk(1,0,0,0,0,0,                       0,32'h0,1,32'h4,32'h55555555));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].frz, tbl[i].bt, tbl[i].baddr, tbl[i].ack, tbl[i].data);
      n_vec++;
      chk("memReq", i, 32'(memReq), 32'(tbl[i].req));
      chk("memAddr", i, memAddr, tbl[i].addr);
      chk("valid", i, 32'(valid), 32'(tbl[i].vld));
      chk("pc", i, pc, tbl[i].pcv);
      chk("instruction", i, instruction, tbl[i].ins);
    end
    // L=4 fetch from 0x4: request held steady until ack, then bounded wait for valid
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      n_vec++;
      chk("hold_req", 100 + i, 32'(memReq), 32'd1);
      chk("hold_addr", 100 + i, memAddr, 32'h4);
      chk("hold_valid", 100 + i, 32'(valid), 32'd0);
    end
    drive(1, 0, 0, 0, 1, 32'h66666666);
    n_vec++;
    chk("ack_addr", 103, memAddr, 32'h4);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      seen = valid;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL wait_valid: got valid=0 after 10 cycles, expected valid=1");
    end else begin
      chk("lat_pc", 104, pc, 32'h8);
      chk("lat_instruction", 104, instruction, 32'h66666666);
      chk("lat_req", 104, 32'(memReq), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the 5-stage pipeline. Owns the program counter, issues requests to a variable-latency instruction memory over a req/ack handshake, applies branch redirects (including while a request is in flight) and presents one fetched instruction plus its PC+4 to the IF/ID pipeline register. Freeze from the hazard unit holds a fetched instruction until the pipeline can accept it.

## Interface
- N, 32, address/instruction width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (rst==0 at a posedge resets)
- freeze  in  1  hazard stall; holds a ready instruction
- branchTaken  in  1  redirect request from EXE
- branchAddr  in  N  redirect target; bits [1:0] ignored
- memReq  out  1  instruction-memory request
- memAddr  out  N  request address, word-aligned
- memAck  in  1  one-cycle pulse; memData valid this cycle
- memData  in  N  instruction word
- valid  out  1  instruction/pc outputs hold a live instruction
- pc  out  N  PC+4 of presented instruction (feeds IF/ID pcIn)
- instruction  out  N  presented instruction (feeds IF/ID instructionIn)

## Operation
- Internal: pcReg (fetch address, [1:0]=0), redirReg, instrReg, pcOutReg, state ∈ {FETCH, READY, DRAIN}.
- Reset values: state=FETCH, pcReg=0, redirReg=0, instrReg=0, pcOutReg=0; outputs valid=0, pc=0, instruction=0, memAddr=0, memReq=0 while rst==0.
- memReq=1 in FETCH and DRAIN (rst==1); memAddr=pcReg always; valid=1 only in READY; pc=pcOutReg; instruction=instrReg.
- FETCH:
  - branchTaken & memAck: discard memData, pcReg<=branchAddr&~3, stay FETCH.
  - branchTaken & ~memAck: redirReg<=branchAddr&~3, go DRAIN (address held stable; requests are never withdrawn).
  - memAck only: instrReg<=memData, pcOutReg<=pcReg+4, go READY.
  - freeze ignored.
- READY:
  - branchTaken (priority over freeze): drop instruction, pcReg<=branchAddr&~3, go FETCH.
  - ~freeze: instruction consumed at this edge; pcReg<=pcReg+4, go FETCH.
  - freeze: hold all.
- DRAIN:
  - memAck: discard memData; pcReg<=branchTaken ? branchAddr&~3 : redirReg; go FETCH.
  - branchTaken & ~memAck: redirReg<=branchAddr&~3 (latest wins).
- Arithmetic: pcReg+4 modulo 2^N; 0xFFFFFFFC wraps to 0.
- memAck outside FETCH/DRAIN is ignored.

## Timing
- Memory latency L≥1 cycles from memReq rise to memAck; memAck may arrive in the first request cycle (L=1).
- Fetch to valid: 1 cycle after memAck edge. Best throughput one instruction per L+1 cycles.
- Consumption: valid & ~freeze & ~branchTaken at a posedge; next memReq asserted in the following cycle.
- Redirect with no request outstanding: new address on memAddr the cycle after branchTaken.
- Redirect in flight: first request to target issued the cycle after the stale memAck.
- Reset mid-operation: state and registers reset at that edge regardless of outstanding request; a memAck arriving after reset release while in FETCH is accepted as response to address 0 (memory must be reset together with this block).

## Structure
- Shared package: state encoding constants (FETCH, READY, DRAIN), PC_STEP=4, PC_RESET=0.
- One sub-module natural: fetch_pc_reg (pcReg with sync active-low reset, load-target, increment-by-4, hold, alignment masking).

## Test plan
- Reset then L=2 memory returning 0xE3A00001 at 0: memAddr=0, valid rises 1 cycle after ack, pc=4, instruction=0xE3A00001; rst=0 mid-stream returns all outputs to 0.
- Freeze held 3 cycles in READY: valid, pc, instruction stable; memReq=0; release -> memAddr=4 next cycle.
- branchTaken=1, branchAddr=0x103 while request to 0x8 outstanding (L=3): DRAIN, 0x8 data discarded, next memAddr=0x100, valid never shows 0x8 word.
- Two branches (0x40 then 0x80) during one outstanding request: only 0x80 fetched.
- branchTaken and freeze both in READY: instruction dropped, memAddr=target next cycle.
- pcReg=0xFFFFFFFC fetch with L=1: pc=0, next memAddr=0.
